// File: rtl/rle_scan_scheduler.sv
// Round-robin frame scheduler in front of a shared run-length encoder.
// One source owns the encoder for a whole frame; tokens leave through one valid/ready register.
module rle_scan_scheduler #(
    parameter int N_REQ  = 4,
    parameter int CODE_W = 4,
    parameter int RUN_W  = 4,
    localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*CODE_W-1:0] req_code,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CODE_W-1:0]       out_code,
    output logic [RUN_W-1:0]        out_run,
    output logic [SRC_W-1:0]        out_src,
    output logic                    out_last,
    output logic                    busy
);
    localparam logic [RUN_W-1:0] RMAX = {RUN_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [SRC_W-1:0]  gnt_reg, last_grant_reg;
    logic [CODE_W-1:0] acc_code_reg, acc_code_next;
    logic [RUN_W-1:0]  acc_run_reg, acc_run_next;
    logic              out_valid_reg, out_valid_next;
    logic [CODE_W-1:0] out_code_reg, out_code_next;
    logic [RUN_W-1:0]  out_run_reg, out_run_next;
    logic [SRC_W-1:0]  out_src_reg, out_src_next;
    logic              out_last_reg, out_last_next;

    logic [CODE_W-1:0] code_arr [N_REQ];
    logic [N_REQ-1:0]  gnt_onehot;
    logic [CODE_W-1:0] cur_code;
    logic              cur_valid, cur_last;

    logic              out_free;
    logic              run_ready, grant_load, flush_load;
    logic              beat_accept, extend;

    // Per-source slicing and the grant decode that gates ready.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_src
            assign code_arr[gi]   = req_code[gi*CODE_W +: CODE_W];
            assign gnt_onehot[gi] = (gnt_reg == SRC_W'(gi));
            assign req_ready[gi]  = run_ready & gnt_onehot[gi];
        end
    endgenerate

    assign cur_valid = |(req_valid & gnt_onehot);
    assign cur_last  = |(req_last & gnt_onehot);

    always_comb begin
        cur_code = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_onehot[i]) begin
                cur_code = code_arr[i];
            end
        end
    end

    // Round-robin search: rotate the doubled request vector so bit 0 is last_grant+1.
    logic [2*N_REQ-1:0] dbl_valid;
    logic [N_REQ-1:0]   rot_valid;
    logic [SRC_W:0]     start_pos, rot_idx, arb_sum;
    logic               arb_found;
    logic [SRC_W-1:0]   arb_idx;

    assign dbl_valid = {req_valid, req_valid};
    assign start_pos = {1'b0, last_grant_reg} + (SRC_W+1)'(1);
    assign rot_valid = dbl_valid[start_pos +: N_REQ];

    always_comb begin
        rot_idx = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rot_valid[j]) begin
                rot_idx = (SRC_W+1)'(j);
            end
        end
        arb_found = |rot_valid;
        arb_sum   = start_pos + rot_idx;
        if (arb_sum >= (SRC_W+1)'(N_REQ)) begin
            arb_sum = arb_sum - (SRC_W+1)'(N_REQ);
        end
        arb_idx = arb_sum[SRC_W-1:0];
    end

    assign out_free = !out_valid_reg || out_ready;

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (arb_found) state_next = RUN;
            RUN:     if (beat_accept && cur_last) state_next = FLUSH;
            FLUSH:   if (out_free) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs and strobes
    always_comb begin
        run_ready  = 1'b0;
        grant_load = 1'b0;
        flush_load = 1'b0;
        case (state_reg)
            IDLE:    grant_load = arb_found;
            RUN:     run_ready  = out_free;
            FLUSH:   flush_load = out_free;
            default: ;
        endcase
    end

    assign beat_accept = run_ready & cur_valid;
    assign extend      = (cur_code == acc_code_reg) && (acc_run_reg != RMAX);
    assign busy        = (state_reg != IDLE);

    // Pointer starts at the top index so source 0 wins the first search.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_reg        <= '0;
            last_grant_reg <= SRC_W'(N_REQ - 1);
        end else if (grant_load) begin
            gnt_reg        <= arb_idx;
            last_grant_reg <= arb_idx;
        end
    end

    always_comb begin
        acc_code_next  = acc_code_reg;
        acc_run_next   = acc_run_reg;
        out_valid_next = out_valid_reg;
        out_code_next  = out_code_reg;
        out_run_next   = out_run_reg;
        out_src_next   = out_src_reg;
        out_last_next  = out_last_reg;

        if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end

        if (beat_accept) begin
            if (acc_run_reg == '0) begin
                acc_code_next = cur_code;
                acc_run_next  = RUN_W'(1);
            end else if (extend) begin
                acc_run_next = acc_run_reg + RUN_W'(1);
            end else begin
                // Differing or saturating beat: ship the old run, restart with this code.
                out_valid_next = 1'b1;
                out_code_next  = acc_code_reg;
                out_run_next   = acc_run_reg;
                out_src_next   = gnt_reg;
                out_last_next  = 1'b0;
                acc_code_next  = cur_code;
                acc_run_next   = RUN_W'(1);
            end
        end

        if (flush_load) begin
            out_valid_next = 1'b1;
            out_code_next  = acc_code_reg;
            out_run_next   = acc_run_reg;
            out_src_next   = gnt_reg;
            out_last_next  = 1'b1;
            acc_code_next  = '0;
            acc_run_next   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_code_reg  <= '0;
            acc_run_reg   <= '0;
            out_valid_reg <= 1'b0;
            out_code_reg  <= '0;
            out_run_reg   <= '0;
            out_src_reg   <= '0;
            out_last_reg  <= 1'b0;
        end else begin
            acc_code_reg  <= acc_code_next;
            acc_run_reg   <= acc_run_next;
            out_valid_reg <= out_valid_next;
            out_code_reg  <= out_code_next;
            out_run_reg   <= out_run_next;
            out_src_reg   <= out_src_next;
            out_last_reg  <= out_last_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_code  = out_code_reg;
    assign out_run   = out_run_reg;
    assign out_src   = out_src_reg;
    assign out_last  = out_last_reg;

endmodule

// File: tb/tb_rle_scan_scheduler.sv
// Directed bench for rle_scan_scheduler: hand-computed tokens, grant order, stall and reset cases.
module tb_rle_scan_scheduler;
    localparam int N  = 4;
    localparam int CW = 4;
    localparam int RW = 4;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [N*CW-1:0] req_code;
    logic [N-1:0]  req_last;
    logic [N-1:0]  req_ready;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_code;
    logic [RW-1:0] out_run;
    logic [SW-1:0] out_src;
    logic          out_last;
    logic          busy;

    rle_scan_scheduler #(.N_REQ(N), .CODE_W(CW), .RUN_W(RW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_code  (req_code),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_run   (out_run),
        .out_src   (out_src),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int tok_q[$];
    int tok_cyc[$];
    int acc_log[$];
    int frame_codes[$];
    int first_acc_cyc;
    int last_acc_cyc;
    int onehot_err;
    int exp_gnt[6] = '{0, 2, 3, 0, 2, 3};
    bit seen;

    // Token packing: code[10:7] run[6:3] src[2:1] last[0].
    function automatic int tok(input int c, input int r, input int s, input int l);
        return (c << 7) | (r << 3) | (s << 1) | l;
    endfunction

    function automatic int cur_tok();
        return tok(int'(out_code), int'(out_run), int'(out_src), int'(out_last));
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s got=%0d", tag, got);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            tok_q.push_back(cur_tok());
            tok_cyc.push_back(cyc);
        end
    end

    task automatic clear_tokens();
        tok_q.delete();
        tok_cyc.delete();
    endtask

    task automatic send_frame(input int src, input bit mark_last);
        bit ok;
        for (int b = 0; b < frame_codes.size(); b++) begin
            req_valid[src] = 1'b1;
            req_code[src*CW +: CW] = CW'(frame_codes[b]);
            req_last[src] = mark_last && (b == frame_codes.size() - 1);
            ok = 1'b0;
            for (int w = 0; w < 60 && !ok; w++) begin
                @(negedge clk);
                ok = req_ready[src];
                if (ok) begin
                    if (b == 0) first_acc_cyc = cyc;
                    last_acc_cyc = cyc;
                end
                @(posedge clk);
                #1;
            end
            chk("beat_accept", int'(ok), 1);
        end
        req_valid[src] = 1'b0;
        req_last[src]  = 1'b0;
    endtask

    task automatic collect_accepts(input int n_want);
        int guard;
        guard = 0;
        while (acc_log.size() < n_want && guard < 200) begin
            @(negedge clk);
            if ($countones(req_ready) > 1) onehot_err++;
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) acc_log.push_back(i);
            end
            @(posedge clk);
            #1;
            guard++;
        end
        req_valid = '0;
        req_last  = '0;
        chk("accept_count", acc_log.size(), n_want);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int w = 0; w < 100 && !done; w++) begin
            @(negedge clk);
            done = !busy && !out_valid;
        end
        chk("drain", int'(done), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_code  = '0;
        req_last  = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_code",  int'(out_code), 0);
        chk("rst_out_run",   int'(out_run), 0);
        chk("rst_out_src",   int'(out_src), 0);
        chk("rst_out_last",  int'(out_last), 0);
        chk("rst_busy",      int'(busy), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Source 0: 3,3,3,5,5
        clear_tokens();
        frame_codes.delete();
        frame_codes.push_back(3); frame_codes.push_back(3); frame_codes.push_back(3);
        frame_codes.push_back(5); frame_codes.push_back(5);
        send_frame(0, 1'b1);
        chk("t1_busy_flush", int'(busy), 1);
        chk("t1_beat_rate", last_acc_cyc - first_acc_cyc, 4);
        wait_idle();
        chk("t1_ntok", tok_q.size(), 2);
        chk("t1_tok0", tok_q[0], tok(3, 3, 0, 0));
        chk("t1_tok1", tok_q[1], tok(5, 2, 0, 1));
        chk("t1_busy_done", int'(busy), 0);

        // Source 1: 17 x A, saturates at 15
        clear_tokens();
        frame_codes.delete();
        for (int k = 0; k < 17; k++) frame_codes.push_back(10);
        send_frame(1, 1'b1);
        wait_idle();
        chk("t2_ntok", tok_q.size(), 2);
        chk("t2_tok0", tok_q[0], tok(10, 15, 1, 0));
        chk("t2_tok1", tok_q[1], tok(10, 2, 1, 1));

        // Fresh pointer, then sources 0,2,3 with continuous one-beat frames
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_tokens();
        acc_log.delete();
        onehot_err = 0;
        req_code  = {4'd3, 4'd2, 4'd0, 4'd1};
        req_last  = 4'b1101;
        req_valid = 4'b1101;
        collect_accepts(6);
        for (int k = 0; k < 6; k++) chk("rr_grant", acc_log[k], exp_gnt[k]);
        chk("rr_onehot", onehot_err, 0);
        wait_idle();
        chk("rr_ntok", tok_q.size(), 6);
        chk("rr_tok0", tok_q[0], tok(1, 1, 0, 1));
        chk("rr_tok1", tok_q[1], tok(2, 1, 2, 1));

        // Stall: source 3 frame 1,2,3 with out_ready low for 4 cycles
        clear_tokens();
        frame_codes.delete();
        frame_codes.push_back(1); frame_codes.push_back(2); frame_codes.push_back(3);
        fork
            send_frame(3, 1'b1);
            begin
                seen = 1'b0;
                for (int w = 0; w < 60 && !seen; w++) begin
                    @(posedge clk);
                    #1;
                    seen = out_valid;
                end
                chk("stall_seen", int'(seen), 1);
                out_ready = 1'b0;
                for (int s = 0; s < 4; s++) begin
                    @(negedge clk);
                    chk("stall_valid", int'(out_valid), 1);
                    chk("stall_hold", cur_tok(), tok(1, 1, 3, 0));
                    chk("stall_ready", int'(req_ready), 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_idle();
        chk("stall_ntok", tok_q.size(), 3);
        chk("stall_tok0", tok_q[0], tok(1, 1, 3, 0));
        chk("stall_tok1", tok_q[1], tok(2, 1, 3, 0));
        chk("stall_tok2", tok_q[2], tok(3, 1, 3, 1));

        // Source 2: single beat 9(last), token two cycles after acceptance
        clear_tokens();
        frame_codes.delete();
        frame_codes.push_back(9);
        send_frame(2, 1'b1);
        wait_idle();
        chk("one_ntok", tok_q.size(), 1);
        chk("one_tok", tok_q[0], tok(9, 1, 2, 1));
        chk("one_latency", tok_cyc[0] - last_acc_cyc, 2);

        // Reset mid-frame with a token held by backpressure
        clear_tokens();
        frame_codes.delete();
        frame_codes.push_back(6); frame_codes.push_back(4);
        send_frame(0, 1'b0);
        out_ready = 1'b0;
        chk("prerst_valid", int'(out_valid), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_code",  int'(out_code), 0);
        chk("mid_rst_run",   int'(out_run), 0);
        chk("mid_rst_busy",  int'(busy), 0);
        chk("mid_rst_ready", int'(req_ready), 0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        clear_tokens();
        acc_log.delete();
        req_code  = {4'd0, 4'd0, 4'd8, 4'd6};
        req_last  = 4'b0011;
        req_valid = 4'b0011;
        collect_accepts(1);
        chk("post_rst_first", acc_log[0], 0);
        wait_idle();
        chk("post_rst_ntok", tok_q.size(), 1);
        chk("post_rst_tok", tok_q[0], tok(6, 1, 0, 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
